// File: rtl/io_timer_pkg.sv
// Shared register map and bit layout for io_timer.
// Build option: IO_TIMER_PWM_EN adds the PWM output and makes CTRL.PWM_EN writable.
package io_timer_pkg;

    localparam int unsigned REG_WINDOW = 5;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_PRE    = 3'd1;
    localparam logic [2:0] OFF_COUNT  = 3'd2;
    localparam logic [2:0] OFF_CMP    = 3'd3;
    localparam logic [2:0] OFF_STATUS = 3'd4;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_CTC      = 1;
    localparam int unsigned CTRL_MATCH_IE = 2;
    localparam int unsigned CTRL_OVF_IE   = 3;
    localparam int unsigned CTRL_PWM_EN   = 4;

    localparam int unsigned STAT_MATCH = 0;
    localparam int unsigned STAT_OVF   = 1;

`ifdef IO_TIMER_PWM_EN
    localparam logic [7:0] CTRL_MASK = 8'h1F;
`else
    localparam logic [7:0] CTRL_MASK = 8'h0F;
`endif

endpackage

// File: rtl/io_timer_prescaler.sv
// Prescaler for io_timer: one-cycle tick every pre+1 clocks while enabled.
module io_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] pre,
    input  logic       restart,
    output logic       tick
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == pre);
        cnt_d = cnt_q + 8'd1;
        if (!en || restart || tick) begin
            cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/io_timer.sv
// 8-bit memory-mapped timer/counter with compare, overflow, irq and optional PWM.
// Build option: define IO_TIMER_PWM_EN to enable the pwm_out comparator.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dMemIOAddress,
    input  logic [7:0]  dMemIOIn,
    input  logic        dMemIOWriteEn,
    input  logic        dMemIOReadEn,
    output logic [7:0]  dataOut,
    output logic        irq,
    output logic        pwm_out
);

    logic [7:0]  ctrl_q, pre_q, count_q, cmp_q, rdata_q;
    logic [7:0]  ctrl_d, pre_d, count_d, cmp_d, rdata_d, rmux;
    logic [1:0]  status_q, status_d;
    logic [15:0] offset;
    logic [2:0]  off;
    logic        hit, wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
    logic        tick, is_match, set_match, set_ovf;

    // Unsigned wrap makes addresses below the base fall outside the window too.
    assign offset = dMemIOAddress - BASE_ADDR;
    assign hit    = offset < 16'(REG_WINDOW);
    assign off    = offset[2:0];

    assign wr_ctrl   = dMemIOWriteEn && hit && (off == OFF_CTRL);
    assign wr_pre    = dMemIOWriteEn && hit && (off == OFF_PRE);
    assign wr_count  = dMemIOWriteEn && hit && (off == OFF_COUNT);
    assign wr_cmp    = dMemIOWriteEn && hit && (off == OFF_CMP);
    assign wr_status = dMemIOWriteEn && hit && (off == OFF_STATUS);

    io_timer_prescaler u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (ctrl_q[CTRL_EN]),
        .pre     (pre_q),
        .restart (wr_ctrl || wr_pre),
        .tick    (tick)
    );

    always_comb begin
        ctrl_d    = wr_ctrl ? (dMemIOIn & CTRL_MASK) : ctrl_q;
        pre_d     = wr_pre ? dMemIOIn : pre_q;
        cmp_d     = wr_cmp ? dMemIOIn : cmp_q;
        count_d   = count_q;
        status_d  = status_q;
        set_match = 1'b0;
        set_ovf   = 1'b0;
        is_match  = (count_q == cmp_q);

        if (wr_status) begin
            status_d = status_q & ~dMemIOIn[1:0];
        end

        // A CPU write to COUNT swallows a coincident tick, flags included.
        if (wr_count) begin
            count_d = dMemIOIn;
        end else if (tick) begin
            set_match = is_match;
            if (ctrl_q[CTRL_CTC] && is_match) begin
                count_d = 8'd0;
            end else begin
                count_d = count_q + 8'd1;
                set_ovf = (count_q == 8'hFF);
            end
        end

        // Hardware set beats a same-cycle software clear.
        status_d[STAT_MATCH] = status_d[STAT_MATCH] | set_match;
        status_d[STAT_OVF]   = status_d[STAT_OVF] | set_ovf;
    end

    always_comb begin
        case (off)
            OFF_CTRL:   rmux = ctrl_q;
            OFF_PRE:    rmux = pre_q;
            OFF_COUNT:  rmux = count_q;
            OFF_CMP:    rmux = cmp_q;
            OFF_STATUS: rmux = {6'd0, status_q};
            default:    rmux = 8'd0;
        endcase
        rdata_d = (dMemIOReadEn && hit) ? rmux : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= 8'd0;
            pre_q    <= 8'd0;
            count_q  <= 8'd0;
            cmp_q    <= 8'd0;
            status_q <= 2'd0;
            rdata_q  <= 8'd0;
        end else begin
            ctrl_q   <= ctrl_d;
            pre_q    <= pre_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign dataOut = rdata_q;
    assign irq     = (status_q[STAT_MATCH] && ctrl_q[CTRL_MATCH_IE]) ||
                     (status_q[STAT_OVF] && ctrl_q[CTRL_OVF_IE]);

`ifdef IO_TIMER_PWM_EN
    logic pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= ctrl_q[CTRL_EN] && ctrl_q[CTRL_PWM_EN] && (count_q < cmp_q);
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_io_timer.sv
// Directed self-checking bench for io_timer: register table plus timed corner sequences.
module tb_io_timer;

    localparam logic [15:0] BASE = 16'h1000;
`ifdef IO_TIMER_PWM_EN
    localparam logic [7:0] CTRL_RB  = 8'h1E;
    localparam logic [7:0] CTRL_PWM = 8'h11;
    localparam int         PWM_HIGH = 64;
`else
    localparam logic [7:0] CTRL_RB  = 8'h0E;
    localparam logic [7:0] CTRL_PWM = 8'h01;
    localparam int         PWM_HIGH = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] dMemIOAddress = 16'h0000;
    logic [7:0]  dMemIOIn = 8'h00;
    logic        dMemIOWriteEn = 1'b0;
    logic        dMemIOReadEn = 1'b0;
    logic [7:0]  dataOut;
    logic        irq;
    logic        pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_timer #(.BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .dMemIOAddress (dMemIOAddress),
        .dMemIOIn      (dMemIOIn),
        .dMemIOWriteEn (dMemIOWriteEn),
        .dMemIOReadEn  (dMemIOReadEn),
        .dataOut       (dataOut),
        .irq           (irq),
        .pwm_out       (pwm_out)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic wr(input logic [2:0] off, input logic [7:0] d);
        dMemIOAddress = BASE | {13'd0, off};
        dMemIOIn      = d;
        dMemIOWriteEn = 1'b1;
        @(negedge clk);
        dMemIOWriteEn = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [7:0] exp, input string name);
        dMemIOAddress = BASE | {13'd0, off};
        dMemIOReadEn  = 1'b1;
        @(negedge clk);
        dMemIOReadEn  = 1'b0;
        chk(name, int'(dataOut), int'(exp));
    endtask

    initial begin
        int hi;

        vecs.push_back('{1'b0, 1'b1, 16'h1000, 8'h00, 8'h00, "rst_ctrl"});
        vecs.push_back('{1'b0, 1'b1, 16'h1001, 8'h00, 8'h00, "rst_pre"});
        vecs.push_back('{1'b0, 1'b1, 16'h1002, 8'h00, 8'h00, "rst_count"});
        vecs.push_back('{1'b0, 1'b1, 16'h1003, 8'h00, 8'h00, "rst_cmp"});
        vecs.push_back('{1'b0, 1'b1, 16'h1004, 8'h00, 8'h00, "rst_status"});
        vecs.push_back('{1'b1, 1'b0, 16'h1001, 8'h03, 8'h00, "wr_pre"});
        vecs.push_back('{1'b0, 1'b1, 16'h1001, 8'h00, 8'h03, "rd_pre"});
        vecs.push_back('{1'b1, 1'b0, 16'h1003, 8'h5A, 8'h00, "wr_cmp"});
        vecs.push_back('{1'b0, 1'b1, 16'h1003, 8'h00, 8'h5A, "rd_cmp"});
        vecs.push_back('{1'b1, 1'b0, 16'h1002, 8'h77, 8'h00, "wr_count"});
        vecs.push_back('{1'b0, 1'b1, 16'h1002, 8'h00, 8'h77, "rd_count"});
        vecs.push_back('{1'b1, 1'b0, 16'h1000, 8'hFE, 8'h00, "wr_ctrl"});
        vecs.push_back('{1'b0, 1'b1, 16'h1000, 8'h00, CTRL_RB, "rd_ctrl_mask"});
        vecs.push_back('{1'b1, 1'b0, 16'h1000, 8'h00, 8'h00, "wr_ctrl0"});
        vecs.push_back('{1'b0, 1'b1, 16'h1000, 8'h00, 8'h00, "rd_ctrl0"});
        vecs.push_back('{1'b1, 1'b0, 16'h1005, 8'hAA, 8'h00, "wr_above"});
        vecs.push_back('{1'b0, 1'b1, 16'h1005, 8'h00, 8'h00, "rd_above"});
        vecs.push_back('{1'b1, 1'b0, 16'h0FFF, 8'hAA, 8'h00, "wr_below"});
        vecs.push_back('{1'b0, 1'b1, 16'h0FFF, 8'h00, 8'h00, "rd_below"});
        vecs.push_back('{1'b0, 1'b1, 16'h1001, 8'h00, 8'h03, "keep_pre"});
        vecs.push_back('{1'b0, 1'b1, 16'h1003, 8'h00, 8'h5A, "keep_cmp"});
        vecs.push_back('{1'b0, 1'b1, 16'h1002, 8'h00, 8'h77, "keep_count"});
        vecs.push_back('{1'b1, 1'b0, 16'h1004, 8'hFF, 8'h00, "wr_status"});
        vecs.push_back('{1'b0, 1'b1, 16'h1004, 8'h00, 8'h00, "keep_status"});
        vecs.push_back('{1'b1, 1'b1, 16'h1002, 8'h12, 8'h77, "rw_old"});
        vecs.push_back('{1'b0, 1'b1, 16'h1002, 8'h00, 8'h12, "rw_new"});

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_irq", int'(irq), 0);
        chk("rst_pwm", int'(pwm_out), 0);

        foreach (vecs[i]) begin
            dMemIOAddress = vecs[i].addr;
            dMemIOIn      = vecs[i].wdata;
            dMemIOWriteEn = vecs[i].we;
            dMemIOReadEn  = vecs[i].re;
            @(negedge clk);
            dMemIOWriteEn = 1'b0;
            dMemIOReadEn  = 1'b0;
            chk(vecs[i].name, int'(dataOut), int'(vecs[i].exp));
        end
        chk("tbl_irq", int'(irq), 0);

        // Free-run overflow with PRE=0: FD -> FE -> FF -> 00.
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h80);
        wr(3'd2, 8'hFD);
        wr(3'd0, 8'h09);
        repeat (3) @(negedge clk);
        rd(3'd2, 8'h00, "ovf_count");
        rd(3'd4, 8'h02, "ovf_status");
        chk("ovf_irq", int'(irq), 1);
        wr(3'd4, 8'h02);
        chk("ovf_irq_clr", int'(irq), 0);
        wr(3'd0, 8'h00);

        // CTC, PRE=3, CMP=5: match every 24 clocks.
        wr(3'd4, 8'h03);
        wr(3'd2, 8'h00);
        wr(3'd1, 8'h03);
        wr(3'd3, 8'h05);
        wr(3'd0, 8'h07);
        repeat (23) @(negedge clk);
        chk("ctc_irq_early", int'(irq), 0);
        @(negedge clk);
        chk("ctc_irq_24", int'(irq), 1);
        rd(3'd2, 8'h00, "ctc_count");
        wr(3'd4, 8'h01);
        chk("ctc_irq_clr", int'(irq), 0);
        repeat (21) @(negedge clk);
        chk("ctc_irq_early2", int'(irq), 0);
        @(negedge clk);
        chk("ctc_irq_48", int'(irq), 1);
        wr(3'd0, 8'h00);

        // COUNT write collides with a tick: write wins.
        wr(3'd4, 8'h03);
        wr(3'd3, 8'h80);
        wr(3'd1, 8'h00);
        wr(3'd0, 8'h01);
        wr(3'd2, 8'h40);
        rd(3'd2, 8'h40, "coll_count");
        wr(3'd0, 8'h00);

        // MATCH set and software clear in the same cycle: set wins.
        wr(3'd4, 8'h03);
        wr(3'd2, 8'h10);
        wr(3'd3, 8'h12);
        wr(3'd0, 8'h01);
        repeat (2) @(negedge clk);
        wr(3'd4, 8'h01);
        rd(3'd4, 8'h01, "coll_status");
        wr(3'd0, 8'h00);
        repeat (5) @(negedge clk);
        rd(3'd2, 8'h15, "freeze_count");

        // PWM duty: CMP=0x40 over a full 256-clock period.
        wr(3'd4, 8'h03);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h40);
        wr(3'd2, 8'h00);
        wr(3'd0, 8'h11);
        rd(3'd0, CTRL_PWM, "pwm_ctrl");
        repeat (3) @(negedge clk);
        hi = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            if (pwm_out === 1'b1) hi++;
        end
        chk("pwm_high", hi, PWM_HIGH);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
